mult_div: RTL and testbench
===========================

# mult_div

Iterative signed multiply/divide unit for the multicycle MIPS datapath, sitting directly downstream of the control unit. It starts when control pulses its multiply/divide command, computes a 64-bit signed product (Booth radix-2) or a signed 32-bit quotient and remainder (restoring division on magnitudes), and holds the HI/LO result. It reports completion and divide-by-zero back to control.

## Interface
- `WIDTH`, 32: operand width; HI/LO are each `WIDTH` bits.
- `clock` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle command pulse from control (MDcontrol); sampled only in IDLE.
- `op` in 1: operation, 0 = MULT, 1 = DIV; sampled with `start`.
- `a` in WIDTH: multiplicand or dividend (signed), sampled with `start`.
- `b` in WIDTH: multiplier or divisor (signed), sampled with `start`.
- `hi` out WIDTH: HI register, product[63:32] or remainder.
- `lo` out WIDTH: LO register, product[31:0] or quotient.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse; HI/LO valid (control raises HILOWrite on it).
- `div0` out 1: one-cycle pulse, divide by zero (control's Div0 input).

## Operation
- States: IDLE, MULT, DIV, FINISH.
- IDLE:
  - On `start=1` with `op=0`: latch `a` and `b`, clear the accumulator and Booth bit q-1, set iteration counter to 0, go to MULT.
  - On `start=1` with `op=1` and `b!=0`: latch |a|, |b| and the two sign bits, clear the partial remainder, go to DIV.
  - On `start=1` with `op=1` and `b==0`: stay in IDLE and pulse `done` and `div0` together; `hi`/`lo` unchanged.
- MULT, one Booth step per cycle:
  - Examine {q0, q-1}: 01 adds the multiplicand to the upper half, 10 subtracts it, 00/11 do nothing.
  - Then arithmetic-shift the 65-bit {A, Q, q-1} right by 1.
  - After 32 steps go to FINISH.
- DIV, one restoring step per cycle on unsigned magnitudes:
  - Shift {R, Q} left by 1, then trial-subtract the divisor.
  - If the result is non-negative, keep it and set Q0=1; otherwise restore and set Q0=0.
  - After 32 steps go to FINISH.
- FINISH:
  - MULT: `hi`=A, `lo`=Q.
  - DIV: quotient negated if the sign bits differ; remainder negated if the dividend was negative (truncation toward zero).
  - Pulse `done`, return to IDLE.
- `start` while `busy=1` is ignored; no queueing.
- `op` values other than those defined do not exist (1-bit port).
- Arithmetic: subtraction is two's complement in WIDTH+1 bits (sign bit is the trial result).
- Overflow case −2^31 / −1 gives `lo`=0x80000000, `hi`=0, with no trap; MIPS leaves this undefined and this block fixes it.
- Reset (asserted at any time, including mid-operation): state IDLE, `hi`=0, `lo`=0, `busy`=0, `done`=0, `div0`=0, counter 0; the partial result is discarded.

## Timing
- Edge E0 samples `start`.
- `busy`:
  - High from after E0.
  - Low from after E33, the same edge at which `done` rises and `hi`/`lo` update.
- Latency: 33 cycles for MULT and DIV.
- `done`: high for exactly one cycle.
- Divide-by-zero: `done`=`div0`=1 for the one cycle after E0; `busy` never rises.
- `hi`/`lo` are stable except at the FINISH edge.
- A new `start` is accepted in the cycle `done` is high, so a back-to-back command is sampled at E34.

## Structure
- Package `mult_div_pkg`:
  - State enum (IDLE/MULT/DIV/FINISH).
  - Op constants OP_MULT=0, OP_DIV=1.
  - Constant ITER=32.
- One sub-module `div_restore_step`: combinational shift/trial-subtract/select for one restoring step. MULT uses an inline Booth step.

## Test plan
- MULT a=7, b=0xFFFFFFFD (−3) -> `done` after E33, `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- MULT a=b=0x7FFFFFFF -> `hi`=0x3FFFFFFF, `lo`=0x00000001. MULT a=0x80000000, b=0x80000000 -> `hi`=0x40000000, `lo`=0.
- DIV a=0xFFFFFFF9 (−7), b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- DIV a=5, b=0 with `hi`/`lo` previously 0x11/0x22 -> `done`=`div0`=1 for one cycle after E0, `busy` stays 0, `hi`=0x11, `lo`=0x22.
- Second `start` at E10 of a MULT -> ignored; the result matches the first operands only. `start` in the `done` cycle -> accepted.
- `reset` low at E15 of a DIV -> immediately `busy`=0, `hi`=`lo`=0. After release, a fresh MULT 3×4 -> `lo`=12, `hi`=0.

Source files
------------

// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the iterative multiply/divide unit.
//   state_t  : controller states (IDLE, MULT, DIV, FINISH)
//   OP_MULT  : op encoding for signed multiply
//   OP_DIV   : op encoding for signed divide
//   ITER     : number of Booth / restoring steps per operation
package mult_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MULT   = 2'd1,
    DIV    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER = 32;

endpackage

// File: rtl/mult_div_div_restore_step.sv
// div_restore_step: one combinational restoring-division step on unsigned magnitudes.
//   rem       in  WIDTH : current partial remainder
//   quo       in  WIDTH : current dividend/quotient shift register
//   divisor   in  WIDTH : divisor magnitude
//   rem_next  out WIDTH : partial remainder after the step
//   quo_next  out WIDTH : quotient register after the step (new bit in LSB)
module div_restore_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift the next dividend bit into the remainder, then trial-subtract in
  // WIDTH+1 bits; the top bit of the difference says whether it went negative.
  // Because rem < divisor on entry, the non-negative result always fits WIDTH bits.
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    trial    = shifted - {1'b0, divisor};
    if (trial[WIDTH]) begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end else begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mult_div.sv
// mult_div: iterative signed multiply (Booth radix-2) / divide (restoring) unit.
//   clock  in  1     : rising-edge clock
//   reset  in  1     : asynchronous active-low reset
//   start  in  1     : command pulse, sampled only in IDLE
//   op     in  1     : 0 = MULT, 1 = DIV
//   a, b   in  WIDTH : signed operands (multiplicand/multiplier or dividend/divisor)
//   hi     out WIDTH : product upper half or remainder
//   lo     out WIDTH : product lower half or quotient
//   busy   out 1     : operation in progress
//   done   out 1     : one-cycle pulse, hi/lo valid
//   div0   out 1     : one-cycle pulse, divide by zero detected
module mult_div
  import mult_div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(ITER) + 1;

  state_t state, next_state;

  logic [CNT_W-1:0] count;
  logic             last_step;

  // acc carries one guard bit so Booth handles the most negative multiplicand.
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             qm1;
  logic [WIDTH-1:0] m;
  logic             op_reg;
  logic             a_neg;
  logic             b_neg;

  logic load_mult, load_div, div_zero, step_mult, step_div, finish;

  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] rem_next, quo_next;
  logic [WIDTH-1:0] rem_raw, quo_fix, rem_fix;

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  assign last_step = (count == CNT_W'(ITER - 1));

  // Next-state logic. A divide by zero never leaves IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == OP_MULT)   next_state = MULT;
          else if (b != '0)    next_state = DIV;
        end
      end
      MULT:    if (last_step) next_state = FINISH;
      DIV:     if (last_step) next_state = FINISH;
      FINISH:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Control decode from the current state and the command inputs.
  always_comb begin
    busy      = (state != IDLE);
    load_mult = (state == IDLE) && start && (op == OP_MULT);
    load_div  = (state == IDLE) && start && (op == OP_DIV) && (b != '0);
    div_zero  = (state == IDLE) && start && (op == OP_DIV) && (b == '0);
    step_mult = (state == MULT);
    step_div  = (state == DIV);
    finish    = (state == FINISH);
  end

  // One Booth step: add/subtract the multiplicand on {q0,q-1} = 01/10, the
  // shift itself is done when the registers are updated.
  always_comb begin
    m_ext = {m[WIDTH-1], m};
    case ({q[0], qm1})
      2'b01:   booth_sum = acc + m_ext;
      2'b10:   booth_sum = acc - m_ext;
      default: booth_sum = acc;
    endcase
  end

  // Operand magnitudes for division; the most negative value maps to itself,
  // which is still correct when read as unsigned.
  always_comb begin
    a_mag = a[WIDTH-1] ? -a : a;
    b_mag = b[WIDTH-1] ? -b : b;
  end

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem      (acc[WIDTH-1:0]),
    .quo      (q),
    .divisor  (m),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  // Sign correction for truncating division: quotient negative when the
  // operand signs differ, remainder takes the dividend's sign.
  always_comb begin
    rem_raw = acc[WIDTH-1:0];
    quo_fix = (a_neg ^ b_neg) ? -q : q;
    rem_fix = a_neg ? -rem_raw : rem_raw;
  end

  // Datapath registers, iteration counter, and the done/div0 pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      q      <= '0;
      qm1    <= 1'b0;
      m      <= '0;
      op_reg <= OP_MULT;
      a_neg  <= 1'b0;
      b_neg  <= 1'b0;
      count  <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      div0   <= 1'b0;
    end else begin
      done <= finish | div_zero;
      div0 <= div_zero;
      if (load_mult) begin
        m      <= a;
        q      <= b;
        acc    <= '0;
        qm1    <= 1'b0;
        count  <= '0;
        op_reg <= OP_MULT;
      end else if (load_div) begin
        m      <= b_mag;
        q      <= a_mag;
        acc    <= '0;
        a_neg  <= a[WIDTH-1];
        b_neg  <= b[WIDTH-1];
        count  <= '0;
        op_reg <= OP_DIV;
      end else if (step_mult) begin
        acc   <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
        q     <= {booth_sum[0], q[WIDTH-1:1]};
        qm1   <= q[0];
        count <= count + CNT_W'(1);
      end else if (step_div) begin
        acc   <= {1'b0, rem_next};
        q     <= quo_next;
        count <= count + CNT_W'(1);
      end else if (finish) begin
        count <= '0;
        if (op_reg == OP_MULT) begin
          hi <= acc[WIDTH-1:0];
          lo <= q;
        end else begin
          hi <= rem_fix;
          lo <= quo_fix;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_div.sv
// tb_mult_div: self-checking bench for mult_div. Directed corner cases plus
// random operations, each compared against a plain-arithmetic reference model.
module tb_mult_div;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic [31:0] hi, lo;
  logic        busy, done, div0;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] expHi = 32'h0;
  logic [31:0] expLo = 32'h0;

  mult_div #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi    (hi),
    .lo    (lo),
    .busy  (busy),
    .done  (done),
    .div0  (div0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: count it, report a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: signed 64-bit arithmetic; divide by zero leaves HI/LO alone.
  task automatic model(input logic o, input logic [31:0] x, input logic [31:0] y);
    longint p, qq, rr;
    if (o == 1'b0) begin
      p = longint'($signed(x)) * longint'($signed(y));
      expHi = p[63:32];
      expLo = p[31:0];
    end else if (y != 32'h0) begin
      qq = longint'($signed(x)) / longint'($signed(y));
      rr = longint'($signed(x)) % longint'($signed(y));
      expHi = rr[31:0];
      expLo = qq[31:0];
    end
  endtask

  // Called at a negedge; presents a command for exactly one rising edge (E0)
  // and returns at the negedge following E0.
  task automatic applyStimulus(input logic o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
  endtask

  // Full operation: stimulus, bounded wait for done, result checks.
  // intrudeAt > 0 issues a second start sampled at that edge number.
  task automatic runOp(input string tag, input logic o, input logic [31:0] x,
                       input logic [31:0] y, input int intrudeAt);
    logic [31:0] prevHi;
    int cycles;
    prevHi = expHi;
    model(o, x, y);
    applyStimulus(o, x, y);
    if (o == 1'b1 && y == 32'h0) begin
      checkOutput({tag, "_done"}, 64'(done), 64'd1);
      checkOutput({tag, "_div0"}, 64'(div0), 64'd1);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
      checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
      checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
      return;
    end
    checkOutput({tag, "_busy_e0"}, 64'(busy), 64'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 40) begin
      @(negedge clock);
      cycles++;
      if (cycles == intrudeAt - 1) begin
        start = 1'b1;
        op    = $urandom_range(0, 1);
        a     = $urandom;
        b     = $urandom | 32'h1;
      end
      if (cycles == intrudeAt) start = 1'b0;
      if (cycles == 20) checkOutput({tag, "_hi_stable"}, 64'(hi), 64'(prevHi));
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd33);
    checkOutput({tag, "_hi"}, 64'(hi), 64'(expHi));
    checkOutput({tag, "_lo"}, 64'(lo), 64'(expLo));
    checkOutput({tag, "_busy_end"}, 64'(busy), 64'd0);
    checkOutput({tag, "_div0_end"}, 64'(div0), 64'd0);
  endtask

  // One idle cycle after a result: done must have fallen.
  task automatic idleCycle(input string tag);
    @(negedge clock);
    checkOutput({tag, "_done_fall"}, 64'(done), 64'd0);
    checkOutput({tag, "_div0_fall"}, 64'(div0), 64'd0);
  endtask

  initial begin
    logic        ro;
    logic [31:0] rx, ry;

    reset = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = 32'h0;
    b     = 32'h0;
    #12;
    checkOutput("rst_hi", 64'(hi), 64'd0);
    checkOutput("rst_lo", 64'(lo), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_div0", 64'(div0), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    runOp("mul_7x-3", 1'b0, 32'd7, 32'hFFFFFFFD, 0);
    idleCycle("mul_7x-3");
    runOp("mul_maxpos", 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 0);
    idleCycle("mul_maxpos");
    runOp("mul_minneg", 1'b0, 32'h80000000, 32'h80000000, 0);
    idleCycle("mul_minneg");
    runOp("div_-7by2", 1'b1, 32'hFFFFFFF9, 32'd2, 0);
    idleCycle("div_-7by2");
    runOp("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 0);
    idleCycle("div_ovf");

    // Preload hi/lo = 0x11/0x22 (0x451 / 0x20), then divide by zero.
    runOp("div_pre", 1'b1, 32'h451, 32'h20, 0);
    idleCycle("div_pre");
    checkOutput("pre_hi", 64'(hi), 64'h11);
    checkOutput("pre_lo", 64'(lo), 64'h22);
    runOp("div_zero", 1'b1, 32'd5, 32'd0, 0);
    idleCycle("div_zero");
    checkOutput("div_zero_busy", 64'(busy), 64'd0);

    // Start sampled at E10 must be ignored; then back-to-back in the done cycle.
    runOp("mul_intrude", 1'b0, 32'h12345, 32'hFFFF0001, 10);
    runOp("b2b_div", 1'b1, 32'h7FFFFFFF, 32'hFFFFFFF0, 0);
    runOp("b2b_mul", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    idleCycle("b2b_mul");

    // Reset mid-division.
    applyStimulus(1'b1, 32'h00C0FFEE, 32'd3);
    repeat (14) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_hi", 64'(hi), 64'd0);
    checkOutput("midrst_lo", 64'(lo), 64'd0);
    expHi = 32'h0;
    expLo = 32'h0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    runOp("mul_3x4", 1'b0, 32'd3, 32'd4, 0);
    idleCycle("mul_3x4");

    // Random mix of operations, including small and zero divisors.
    for (int i = 0; i < 16; i++) begin
      ro = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 100)) - 32'd50;
      runOp($sformatf("rand%0d", i), ro, rx, ry, 0);
      idleCycle($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
